// File: rtl/matrix_print_engine.sv
// Prints matrices read from word storage as decimal ASCII to a UART, one DATA_W-cycle double-dabble per element.
// Bytes are offered only while tx_ready=1, with one dead cycle after every send; define DISP_SIGNED_EN for two's complement elements.
module matrix_print_engine #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DIM_W  = 3,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DIM_W-1:0]  disp_m,
  input  logic [DIM_W-1:0]  disp_n,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  total_cnt,
  output logic [ADDR_W-1:0] req_addr,
  output logic              rd_en,
  input  logic [DATA_W-1:0] storage_rdata,
  input  logic              tx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_en,
  output logic              busy,
  output logic              done
);

  localparam int HW = ((DIM_W > CNT_W) ? DIM_W : CNT_W) + 1;
  localparam int HD = HW / 3 + 1;
  localparam int ED = DATA_W / 3 + 1;
  localparam int IW = $clog2(ED + HD + 1);
  localparam int CW = $clog2(DATA_W + 1);

  localparam logic [1:0] M_SINGLE  = 2'd0;
  localparam logic [1:0] M_LIST    = 2'd1;
  localparam logic [1:0] M_SUMMARY = 2'd2;

  typedef enum logic [2:0] {IDLE, HDR, RD_REQ, RD_WAIT, CONV, EMIT, SEP, DONE} state_t;

  state_t state, state_nxt;

  logic [1:0]        mode_q;
  logic [DIM_W-1:0]  m_q, n_q, r_q, c_q;
  logic [CNT_W-1:0]  cnt_q, k_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        fld;
  logic [IW-1:0]     hdr_cnt, dig_cnt;
  logic [ED*4-1:0]   dd_bcd;
  logic [DATA_W-1:0] dd_bin;
  logic [CW-1:0]     conv_cnt;
  logic              gap;

  logic [HW-1:0]     hdr_val;
  logic [HD*4-1:0]   hdr_bcd;
  logic [IW-1:0]     hdr_top, elem_top;
  logic [3:0]        hdr_digit, elem_digit;
  logic [ED*4-1:0]   bcd_adj;
  logic [DATA_W-1:0] elem_mag;
  logic              offer;
  logic [7:0]        tx_byte;

`ifdef DISP_SIGNED_EN
  logic sign_pend;

  // The sign byte goes out ahead of the magnitude digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sign_pend <= 1'b0;
    else if (state == RD_WAIT)
      sign_pend <= storage_rdata[DATA_W-1];
    else if (state == EMIT && tx_en)
      sign_pend <= 1'b0;
  end

  assign elem_mag = storage_rdata[DATA_W-1] ? (~storage_rdata + DATA_W'(1)) : storage_rdata;
`else
  logic sign_pend;

  assign sign_pend = 1'b0;
  assign elem_mag  = storage_rdata;
`endif

  function automatic logic [HD*4-1:0] hdr_to_bcd(input logic [HW-1:0] v);
    logic [HD*4-1:0] b;
    b = '0;
    for (int i = HW - 1; i >= 0; i--) begin
      for (int d = 0; d < HD; d++)
        if (b[d*4 +: 4] >= 4'd5) b[d*4 +: 4] = b[d*4 +: 4] + 4'd3;
      b = {b[HD*4-2:0], v[i]};
    end
    return b;
  endfunction

  logic hdr_num, hdr_fld_end, last_col, last_row, last_mat, elems_empty, elem_last, job_empty;

  assign hdr_num     = (fld == 3'd0) || (fld == 3'd2) || (fld == 3'd4);
  assign hdr_fld_end = !hdr_num || (hdr_cnt == hdr_top);
  assign last_col    = (c_q == n_q - DIM_W'(1));
  assign last_row    = (r_q == m_q - DIM_W'(1));
  assign last_mat    = (k_q == cnt_q - CNT_W'(1));
  assign elems_empty = (m_q == '0) || (n_q == '0);
  assign elem_last   = (dig_cnt == elem_top);
  assign job_empty   = (mode == 2'd3) ||
                       (mode == M_SINGLE && (disp_m == '0 || disp_n == '0)) ||
                       (mode == M_LIST && total_cnt == '0);

  // Header fields: 0=number, 1='*', 2=number, 3='*', 4=number, 5=LF; LIST uses only 0 and 5.
  always_comb begin
    case (fld)
      3'd0:    hdr_val = (mode_q == M_SUMMARY) ? HW'(m_q) : HW'(k_q) + HW'(1);
      3'd2:    hdr_val = HW'(n_q);
      3'd4:    hdr_val = HW'(cnt_q);
      default: hdr_val = '0;
    endcase
    hdr_bcd    = hdr_to_bcd(hdr_val);
    hdr_top    = '0;
    elem_top   = '0;
    hdr_digit  = '0;
    elem_digit = '0;
    bcd_adj    = dd_bcd;
    for (int d = 0; d < HD; d++)
      if (hdr_bcd[d*4 +: 4] != 4'd0) hdr_top = IW'(d);
    for (int d = 0; d < ED; d++)
      if (dd_bcd[d*4 +: 4] != 4'd0) elem_top = IW'(d);
    for (int d = 0; d < HD; d++)
      if (IW'(d) == hdr_top - hdr_cnt) hdr_digit = hdr_bcd[d*4 +: 4];
    for (int d = 0; d < ED; d++)
      if (IW'(d) == elem_top - dig_cnt) elem_digit = dd_bcd[d*4 +: 4];
    for (int d = 0; d < ED; d++)
      if (dd_bcd[d*4 +: 4] >= 4'd5) bcd_adj[d*4 +: 4] = dd_bcd[d*4 +: 4] + 4'd3;
  end

  always_comb begin
    offer   = 1'b0;
    tx_byte = 8'h00;
    case (state)
      HDR: begin
        offer = (mode_q != M_SINGLE) && !gap;
        if (hdr_num)          tx_byte = 8'h30 + {4'h0, hdr_digit};
        else if (fld == 3'd5) tx_byte = 8'h0A;
        else                  tx_byte = 8'h2A;
      end
      EMIT: begin
        offer   = !gap;
        tx_byte = sign_pend ? 8'h2D : 8'h30 + {4'h0, elem_digit};
      end
      SEP: begin
        offer   = !gap;
        tx_byte = last_col ? 8'h0A : 8'h20;
      end
      default: ;
    endcase
  end

  assign tx_en    = offer & tx_ready;
  assign tx_data  = offer ? tx_byte : 8'h00;
  assign rd_en    = (state == RD_REQ);
  assign req_addr = addr_q;
  assign busy     = (state != IDLE) && (state != DONE);
  assign done     = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = job_empty ? DONE : HDR;
      HDR: begin
        if (mode_q == M_SINGLE)
          state_nxt = RD_REQ;
        else if (tx_en && hdr_fld_end && fld == 3'd5) begin
          if (mode_q != M_LIST)  state_nxt = DONE;
          else if (!elems_empty) state_nxt = RD_REQ;
          else if (last_mat)     state_nxt = DONE;
        end
      end
      RD_REQ:  state_nxt = RD_WAIT;
      RD_WAIT: state_nxt = CONV;
      CONV:    if (conv_cnt == CW'(DATA_W - 1)) state_nxt = EMIT;
      EMIT:    if (tx_en && !sign_pend && elem_last) state_nxt = SEP;
      SEP: begin
        if (tx_en) begin
          if (!last_col || !last_row)               state_nxt = RD_REQ;
          else if (mode_q == M_LIST && !last_mat)   state_nxt = HDR;
          else                                      state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= '0;
      m_q      <= '0;
      n_q      <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      k_q      <= '0;
      r_q      <= '0;
      c_q      <= '0;
      fld      <= '0;
      hdr_cnt  <= '0;
      dig_cnt  <= '0;
      dd_bcd   <= '0;
      dd_bin   <= '0;
      conv_cnt <= '0;
      gap      <= 1'b0;
    end else begin
      gap <= tx_en;
      case (state)
        IDLE: if (start) begin
          mode_q  <= mode;
          m_q     <= disp_m;
          n_q     <= disp_n;
          cnt_q   <= total_cnt;
          addr_q  <= base_addr;
          k_q     <= '0;
          r_q     <= '0;
          c_q     <= '0;
          fld     <= '0;
          hdr_cnt <= '0;
        end
        HDR: if (tx_en) begin
          if (!hdr_fld_end) hdr_cnt <= hdr_cnt + IW'(1);
          else begin
            hdr_cnt <= '0;
            case (fld)
              3'd0: fld <= (mode_q == M_LIST) ? 3'd5 : 3'd1;
              3'd5: begin
                fld <= 3'd0;
                if (elems_empty && !last_mat) k_q <= k_q + CNT_W'(1);
              end
              default: fld <= fld + 3'd1;
            endcase
          end
        end
        RD_WAIT: begin
          dd_bin   <= elem_mag;
          dd_bcd   <= '0;
          conv_cnt <= '0;
          dig_cnt  <= '0;
        end
        CONV: begin
          {dd_bcd, dd_bin} <= {bcd_adj, dd_bin} << 1;
          conv_cnt         <= conv_cnt + CW'(1);
        end
        EMIT: if (tx_en && !sign_pend) dig_cnt <= dig_cnt + IW'(1);
        // Consecutive matrices are contiguous, so a running address covers base + k*m*n + i.
        SEP: if (tx_en) begin
          addr_q <= addr_q + ADDR_W'(1);
          if (!last_col) c_q <= c_q + DIM_W'(1);
          else begin
            c_q <= '0;
            if (!last_row) r_q <= r_q + DIM_W'(1);
            else begin
              r_q <= '0;
              if (!last_mat) k_q <= k_q + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
